// File: rtl/parking_pkg.sv
// Shared constants for the parking controller, plus a width helper
// that the debouncer uses for its counters.
package parking_pkg;

    localparam int CLK_HZ                   = 40_000_000;
    localparam int DEB_TICK_DIV_10US        = 400;
    localparam int DEB_STABLE_TICKS_DEFAULT = 16;

    // A count that runs from 0 to n-1 needs this many bits; never fewer than one.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: input synchroniser, tick-qualified persistence counter,
// accepted-level flop and registered rise/fall pulses.
module debounce_channel
    import parking_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
    parameter bit RESET_VALUE  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic noisy,
    output logic stable,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int CNT_W = width_of(STABLE_TICKS);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   sync;

    assign sync = sync_q[SYNC_STAGES-1];

    // The top level uses this to register any_change on the same edge as the pulses.
    assign accept = (sync != stable) && tick && (cnt == CNT_W'(STABLE_TICKS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
            stable <= RESET_VALUE;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], noisy};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync == stable) begin
                cnt <= '0;
            end else if (accept) begin
                stable <= sync;
                cnt    <= '0;
                rise   <= sync;
                fall   <= ~sync;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: one shared sample-tick prescaler feeding
// CHANNELS independent debounce lanes, plus a registered any_change flag.
module multi_debouncer
    import parking_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int TICK_DIV     = DEB_TICK_DIV_10US,
    parameter int STABLE_TICKS = DEB_STABLE_TICKS_DEFAULT,
    parameter bit RESET_VALUE  = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] noisy_signal,
    output logic [CHANNELS-1:0] stable_signal,
    output logic [CHANNELS-1:0] rise_pulse,
    output logic [CHANNELS-1:0] fall_pulse,
    output logic                any_change
);

    localparam int PRE_W = width_of(TICK_DIV);

    if (CHANNELS < 1) begin : g_bad_channels
        $error("multi_debouncer: CHANNELS must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("multi_debouncer: SYNC_STAGES must be >= 2");
    end
    if (TICK_DIV < 1) begin : g_bad_div
        $error("multi_debouncer: TICK_DIV must be >= 1");
    end
    if (STABLE_TICKS < 1) begin : g_bad_ticks
        $error("multi_debouncer: STABLE_TICKS must be >= 1");
    end

    logic [PRE_W-1:0]    pre_cnt;
    logic                tick;
    logic [CHANNELS-1:0] accept;

    // With TICK_DIV=1 the count stays at zero and tick is permanently high.
    assign tick = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_cnt    <= '0;
            any_change <= 1'b0;
        end else begin
            pre_cnt    <= tick ? '0 : pre_cnt + PRE_W'(1);
            any_change <= |accept;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS),
            .RESET_VALUE (RESET_VALUE)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .tick  (tick),
            .noisy (noisy_signal[i]),
            .stable(stable_signal[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i]),
            .accept(accept[i])
        );
    end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: three instances (fast tick, prescaled tick,
// reset value 1) exercised from one stimulus thread plus a pulse scoreboard.
module tb_multi_debouncer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Instance A: TICK_DIV=1, STABLE_TICKS=4
    logic       rst_a;
    logic [3:0] noisy_a, stable_a, rise_a, fall_a;
    logic       any_a;
    multi_debouncer #(.CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_VALUE(1'b0)) u_a (
        .clk(clk), .reset(rst_a), .noisy_signal(noisy_a), .stable_signal(stable_a),
        .rise_pulse(rise_a), .fall_pulse(fall_a), .any_change(any_a));

    // Instance B: TICK_DIV=10, STABLE_TICKS=3
    logic       rst_b;
    logic [3:0] noisy_b, stable_b, rise_b, fall_b;
    logic       any_b;
    multi_debouncer #(.CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(10), .STABLE_TICKS(3), .RESET_VALUE(1'b0)) u_b (
        .clk(clk), .reset(rst_b), .noisy_signal(noisy_b), .stable_signal(stable_b),
        .rise_pulse(rise_b), .fall_pulse(fall_b), .any_change(any_b));

    // Instance C: RESET_VALUE=1
    logic       rst_c;
    logic [3:0] noisy_c, stable_c, rise_c, fall_c;
    logic       any_c;
    multi_debouncer #(.CHANNELS(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4), .RESET_VALUE(1'b1)) u_c (
        .clk(clk), .reset(rst_c), .noisy_signal(noisy_c), .stable_signal(stable_c),
        .rise_pulse(rise_c), .fall_pulse(fall_c), .any_change(any_c));

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    ev_t sb_q[$];
    ev_t ev;

    task automatic expect_pulse(input int at, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.cyc  = at;
        e.rise = r;
        e.fall = f;
        sb_q.push_back(e);
    endtask

    // Every pulse cycle on instance A must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rise_a != 4'd0 || fall_a != 4'd0 || any_a) begin
            if (sb_q.size() == 0) begin
                check("a_unexpected_pulse", {23'd0, any_a, rise_a, fall_a}, 32'd0);
            end else begin
                ev = sb_q.pop_front();
                check("a_pulse_cycle", cyc, ev.cyc);
                check("a_rise", {28'd0, rise_a}, {28'd0, ev.rise});
                check("a_fall", {28'd0, fall_a}, {28'd0, ev.fall});
                check("a_any_change", {31'd0, any_a}, 32'd1);
            end
        end else if (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            check("a_missed_pulse_cycle", cyc, sb_q[0].cyc);
            void'(sb_q.pop_front());
        end
    end

    task automatic wait_b(input int ch, input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stable_b[ch] == lvl) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check("b_wait_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int t0, a1, a_edge, lat;

    initial begin
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        noisy_a = 4'h0; noisy_b = 4'h0; noisy_c = 4'hF;
        repeat (3) @(negedge clk);

        check("a_reset_stable", {28'd0, stable_a}, 32'd0);
        check("a_reset_pulses", {23'd0, any_a, rise_a, fall_a}, 32'd0);
        check("c_reset_stable", {28'd0, stable_c}, 32'hF);
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (3) @(negedge clk);

        // Clean rising edge on ch0: six edges to acceptance.
        noisy_a[0] = 1'b1;
        expect_pulse(cyc + 6, 4'b0001, 4'b0000);
        repeat (5) @(negedge clk);
        check("a_ch0_before", {31'd0, stable_a[0]}, 32'd0);
        @(negedge clk);
        check("a_ch0_after", {31'd0, stable_a[0]}, 32'd1);
        repeat (4) @(negedge clk);

        // Three-cycle glitch on ch1 must be rejected.
        noisy_a[1] = 1'b1;
        repeat (3) @(negedge clk);
        noisy_a[1] = 1'b0;
        repeat (10) @(negedge clk);
        check("a_glitch_rejected", {31'd0, stable_a[1]}, 32'd0);

        // Bounce 1,0,1,1,... accepted six edges after the final 0->1.
        noisy_a[1] = 1'b1;
        @(negedge clk);
        noisy_a[1] = 1'b0;
        @(negedge clk);
        noisy_a[1] = 1'b1;
        expect_pulse(cyc + 6, 4'b0010, 4'b0000);
        repeat (10) @(negedge clk);
        check("a_bounce_accepted", {31'd0, stable_a[1]}, 32'd1);

        // Simultaneous opposite edges on ch0 and ch3, both ways round.
        noisy_a[0] = 1'b0; noisy_a[3] = 1'b1;
        expect_pulse(cyc + 6, 4'b1000, 4'b0001);
        repeat (10) @(negedge clk);
        noisy_a[0] = 1'b1; noisy_a[3] = 1'b0;
        expect_pulse(cyc + 6, 4'b0001, 4'b1000);
        repeat (10) @(negedge clk);
        check("a_simul_state", {28'd0, stable_a}, 32'h3);
        noisy_a[1:0] = 2'b00;
        expect_pulse(cyc + 6, 4'b0000, 4'b0011);
        repeat (10) @(negedge clk);
        check("a_all_low", {28'd0, stable_a}, 32'h0);

        // Reset while ch0 counter sits at 2; full requalification afterwards.
        noisy_a[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("a_midreset_stable", {28'd0, stable_a}, 32'h0);
        repeat (3) @(negedge clk);
        check("a_midreset_held", {28'd0, stable_a}, 32'h0);
        rst_a = 1'b1;
        expect_pulse(cyc + 6, 4'b0001, 4'b0000);
        repeat (5) @(negedge clk);
        check("a_requal_before", {31'd0, stable_a[0]}, 32'd0);
        @(negedge clk);
        check("a_requal_after", {31'd0, stable_a[0]}, 32'd1);
        repeat (5) @(negedge clk);
        check("a_scoreboard_left", sb_q.size(), 32'd0);

        // RESET_VALUE=1 instance: mid-run reset, inputs held high, no pulses.
        rst_c = 1'b0;
        #1;
        check("c_midreset_stable", {28'd0, stable_c}, 32'hF);
        repeat (2) @(negedge clk);
        rst_c = 1'b1;
        #1;
        check("c_release_stable", {28'd0, stable_c}, 32'hF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("c_no_pulse", {23'd0, any_c, rise_c, fall_c}, 32'd0);
        end

        // Prescaled instance: ch2 held high is accepted within 2+30 cycles.
        @(negedge clk);
        noisy_b[2] = 1'b1;
        t0 = cyc;
        wait_b(2, 1'b1, a1);
        lat = a1 - t0;
        check("b_latency_in_range", {31'd0, (lat >= 23 && lat <= 32)}, 32'd1);
        check("b_rise_pulse", {28'd0, rise_b}, 32'h4);
        check("b_any_change", {31'd0, any_b}, 32'd1);
        @(negedge clk);
        check("b_rise_one_cycle", {23'd0, any_b, rise_b, fall_b}, 32'd0);

        // Acceptance lands on a tick edge, so the tick phase is now known.
        noisy_b[2] = 1'b0;
        repeat (28) @(negedge clk);
        check("b_fall_before", {31'd0, stable_b[2]}, 32'd1);
        @(negedge clk);
        check("b_fall_cycle", cyc, a1 + 30);
        check("b_fall_after", {31'd0, stable_b[2]}, 32'd0);
        check("b_fall_pulse", {28'd0, fall_b}, 32'h4);
        a_edge = cyc;

        // Rise again; a 9-cycle low glitch after the second tick restarts the count.
        @(negedge clk);
        noisy_b[2] = 1'b1;
        repeat (19) @(negedge clk);
        noisy_b[2] = 1'b0;
        repeat (9) @(negedge clk);
        noisy_b[2] = 1'b1;
        @(negedge clk);
        check("b_glitch_cycle", cyc, a_edge + 30);
        check("b_glitch_no_accept", {31'd0, stable_b[2]}, 32'd0);
        repeat (29) @(negedge clk);
        check("b_delayed_before", {31'd0, stable_b[2]}, 32'd0);
        @(negedge clk);
        check("b_delayed_after", {31'd0, stable_b[2]}, 32'd1);
        check("b_delayed_rise", {28'd0, rise_b}, 32'h4);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_debouncer.md
# multi_debouncer

Parametrised, multi-channel successor to the single-input debouncer, used in the parking controller to clean entry/exit beam sensors and push-buttons. Each channel is synchronised to `clk` and filtered against a shared tick prescaler. A new stable level is accepted only after it has persisted for a programmable number of consecutive ticks. The block also emits one-cycle rise and fall pulses per channel, so downstream FSMs (car counter, gate control) need no edge detection of their own.

## Interface
- `CHANNELS`, 4: number of independent inputs (≥1).
- `SYNC_STAGES`, 2: synchroniser flops per channel (≥2).
- `TICK_DIV`, 400: `clk` cycles per sample tick (≥1); 400 gives 10 µs at 40 MHz; 1 means a tick every cycle.
- `STABLE_TICKS`, 16: consecutive differing ticks needed to accept a new level (≥1).
- `RESET_VALUE`, 0: 1-bit level loaded into synchronisers and `stable_signal` at reset (applies to all channels).

- `clk`  in  1  system clock, 40 MHz nominal.
- `reset`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `noisy_signal`  in  CHANNELS  raw asynchronous inputs.
- `stable_signal`  out  CHANNELS  debounced levels.
- `rise_pulse`  out  CHANNELS  one-cycle high when the matching `stable_signal` bit goes 0→1.
- `fall_pulse`  out  CHANNELS  one-cycle high when the matching `stable_signal` bit goes 1→0.
- `any_change`  out  1  registered OR of all rise/fall pulses, same cycle as the pulses.

## Operation
- Reset (`reset`=0, asynchronous) sets:
  - every synchroniser flop and every `stable_signal` bit to `RESET_VALUE`;
  - all per-channel counters, the prescaler, `rise_pulse`, `fall_pulse` and `any_change` to 0.
- Prescaler:
  - counts 0..TICK_DIV-1 and wraps;
  - `tick` is high during the cycle in which the count equals TICK_DIV-1;
  - with TICK_DIV=1, `tick` is constantly high.
- Per channel, with `sync` the last synchroniser stage:
  - `sync == stable`: counter clears to 0 on every `clk` edge, regardless of `tick`. A glitch shorter than one tick period therefore restarts qualification.
  - `sync != stable`, `tick` high, counter < STABLE_TICKS-1: counter increments.
  - `sync != stable`, `tick` high, counter == STABLE_TICKS-1: `stable` takes the value of `sync`, counter clears, and the matching rise or fall pulse is asserted for that one cycle.
  - `sync != stable`, `tick` low: counter holds.
- Pulses are registered and are never high for more than one cycle. Rise and fall never fire together on the same channel.
- Channels are fully independent. Several channels may pulse in the same cycle; `any_change` is still a single 1-cycle high.
- Counter width is $clog2(STABLE_TICKS) (minimum 1). Prescaler width is $clog2(TICK_DIV) (minimum 1). No overflow is possible: the counter never exceeds STABLE_TICKS-1.
- Reset asserted mid-qualification discards the partial count. No pulse is generated for the reset-induced level.

## Timing
- Worst-case latency from an input change to `stable_signal` is SYNC_STAGES + TICK_DIV·STABLE_TICKS cycles. The minimum with TICK_DIV=1 is SYNC_STAGES + STABLE_TICKS.
- Latency example (TICK_DIV=1, SYNC_STAGES=2, STABLE_TICKS=4), input changed before edge 0:
  - `sync` updates at edge 1;
  - counter reaches 1/2/3 at edges 2/3/4;
  - `stable_signal` and the pulse update at edge 5, i.e. 6 edges after the change.
- `rise_pulse`/`fall_pulse`/`any_change` change on the same edge as `stable_signal`.
- All outputs are driven directly from flops; there is no combinational input-to-output path.

## Structure
- `parking_pkg` holds the shared constants:
  - `CLK_HZ = 40_000_000`;
  - `DEB_TICK_DIV_10US = 400`;
  - `DEB_STABLE_TICKS_DEFAULT = 16`.
- Sub-module `debounce_channel` contains the synchroniser, counter, stable flop and edge pulses for one channel. It is instantiated CHANNELS times via generate and shares the single `tick` from the top-level prescaler.
- Top level contains only the prescaler, the generate loop and the `any_change` register.
- Parameter legality (ranges above) is checked at elaboration; an illegal value is a `$error`.

## Test plan
- Reset check: CHANNELS=4, RESET_VALUE=1. Assert `reset`=0 mid-run, then release → `stable_signal`=4'b1111 immediately, no pulses for 20 cycles with inputs held at 1.
- Clean edge (TICK_DIV=1, STABLE_TICKS=4): step ch0 0→1 → `stable_signal[0]`=1 exactly 6 edges later; `rise_pulse[0]` and `any_change` high for exactly 1 cycle.
- Glitch rejection: 3-cycle high pulse on ch1 → no change on `stable_signal[1]`, no pulses. Bounce pattern 1,0,1,1,1,1 → `stable_signal[1]` rises 6 edges after the final 0→1.
- Prescaler (TICK_DIV=10, STABLE_TICKS=3): hold ch2 high → accepted within 2+30 cycles. A 9-cycle low glitch inserted before the third tick → counter restarts and acceptance is delayed by ≥30 cycles.
- Simultaneous events: ch0 rising and ch3 falling on the same cycle → both pulses in the same cycle, `any_change` high for 1 cycle only.
- Reset mid-operation: assert `reset` while the ch0 counter is at 2 → after release, ch0 needs a full 4 ticks again and no pulse appears during reset.
